// File: rtl/irq_ctrl.sv
// irq_ctrl: vectored interrupt controller between the IRQ pins and the CPU control unit.
// Each irq line is synchronised, latched per channel in level or edge mode, and masked.
// The lowest pending unmasked channel is then offered to the pipeline through a
// req/ack/done handshake.
//
// Ports:
//   clk, reset_        clock, asynchronous active-low reset
//   irq                raw asynchronous interrupt lines, active high
//   int_en             global interrupt enable
//   vec_base           vector table base (word address)
//   reg_we/sel/wdata   config write: 0 MASK, 1 EDGE, 2 PENDING (W1C), 3 STATUS (read-only)
//   reg_rdata          combinational read of the register selected by reg_sel
//   int_req/id/vector  registered request, winning channel, vector address
//   int_ack, int_done  request accepted / handler returned (single-cycle pulses)
//   in_service         high while a handler is running
module irq_ctrl #(
  parameter int unsigned IRQ_CH          = 8,
  parameter int unsigned ADDR_W          = 30,
  parameter int unsigned VEC_STRIDE_LOG2 = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  localparam int unsigned ID_W           = (IRQ_CH > 1) ? $clog2(IRQ_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [IRQ_CH-1:0] irq,
  input  logic              int_en,
  input  logic [ADDR_W-1:0] vec_base,
  input  logic              reg_we,
  input  logic [1:0]        reg_sel,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              int_req,
  output logic [ID_W-1:0]   int_id,
  output logic [ADDR_W-1:0] int_vector,
  input  logic              int_ack,
  input  logic              int_done,
  output logic              in_service
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e            r_state, w_state_d;
  logic [ID_W-1:0]   r_id, w_id_d;
  logic [IRQ_CH-1:0] r_sync [SYNC_STAGES];
  logic [IRQ_CH-1:0] r_prev;
  logic [IRQ_CH-1:0] r_mask, r_edge, r_pend;
  logic [IRQ_CH-1:0] w_s_irq, w_rise, w_clr, w_ack_clr, w_pend_d, w_elig;
  logic [ID_W-1:0]   w_win;
  logic              w_ack_acc, w_pend_wr;
  logic [31:0]       w_rdata;

  if (IRQ_CH < 32) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^reg_wdata[31:IRQ_CH];
  end

  // Synchroniser chains plus one extra flop for edge detection.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= irq;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s_irq   = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s_irq & ~r_prev;
  assign w_ack_acc = (r_state == StReq) && int_ack;
  assign w_pend_wr = reg_we && (reg_sel == 2'd2);
  assign w_ack_clr = w_ack_acc ? (IRQ_CH'(1) << r_id) : '0;
  assign w_clr     = (w_pend_wr ? reg_wdata[IRQ_CH-1:0] : '0) | w_ack_clr;
  // Level channels track the pin; edge channels hold until cleared, a new edge beats a clear.
  assign w_pend_d  = (r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & w_s_irq);
  assign w_elig    = r_pend & ~r_mask;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_mask <= '1;
      r_edge <= '0;
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_d;
      if (reg_we && reg_sel == 2'd0) r_mask <= reg_wdata[IRQ_CH-1:0];
      if (reg_we && reg_sel == 2'd1) r_edge <= reg_wdata[IRQ_CH-1:0];
    end
  end

  // Fixed priority: scanning downwards leaves the lowest eligible index.
  always_comb begin
    w_win = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_id_d    = r_id;
    unique case (r_state)
      StIdle: begin
        if (int_en && |w_elig) begin
          w_state_d = StReq;
          w_id_d    = w_win;
        end
      end
      StReq: begin
        // int_id stays frozen here; a newly arriving higher priority waits its turn.
        if (int_ack)                        w_state_d = StService;
        else if (!int_en || !w_elig[r_id]) w_state_d = StIdle;
      end
      StService: begin
        if (int_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= StIdle;
      r_id    <= '0;
    end else begin
      r_state <= w_state_d;
      r_id    <= w_id_d;
    end
  end

  assign int_req    = (r_state == StReq);
  assign in_service = (r_state == StService);
  assign int_id     = r_id;
  assign int_vector = vec_base + (ADDR_W'(r_id) << VEC_STRIDE_LOG2);

  always_comb begin
    w_rdata = '0;
    unique case (reg_sel)
      2'd0: w_rdata[IRQ_CH-1:0] = r_mask;
      2'd1: w_rdata[IRQ_CH-1:0] = r_edge;
      2'd2: w_rdata[IRQ_CH-1:0] = r_pend;
      2'd3: begin
        w_rdata[31]  = in_service;
        w_rdata[30]  = int_req;
        w_rdata[7:0] = 8'(r_id);
      end
      default: w_rdata = '0;
    endcase
  end

  assign reg_rdata = w_rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  localparam int N  = 8;
  localparam int S  = 2;
  localparam int AW = 30;
  localparam int SL = 2;

  logic          clk = 1'b0;
  logic          reset_;
  logic [N-1:0]  irq;
  logic          int_en;
  logic [AW-1:0] vec_base;
  logic          reg_we;
  logic [1:0]    reg_sel;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic          int_req;
  logic [2:0]    int_id;
  logic [AW-1:0] int_vector;
  logic          int_ack;
  logic          int_done;
  logic          in_service;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sampled irq history, register images, handshake phase
  // (0 idle, 1 requesting, 2 in service) and the offered channel.
  logic [N-1:0] q_hist[$];
  logic [N-1:0] m_mask, m_edge, m_pend;
  int           m_mode, m_id;

  irq_ctrl #(.IRQ_CH(N), .ADDR_W(AW), .VEC_STRIDE_LOG2(SL), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_(reset_), .irq(irq), .int_en(int_en), .vec_base(vec_base),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .int_req(int_req), .int_id(int_id), .int_vector(int_vector), .int_ack(int_ack),
    .int_done(int_done), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    q_hist.delete();
    repeat (S + 1) q_hist.push_back('0);
    m_mask = '1; m_edge = '0; m_pend = '0; m_mode = 0; m_id = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [N-1:0] s_now, s_old, elig, nxt;
    logic         acc, clr;
    s_now = q_hist[S-1];
    s_old = q_hist[S];
    elig  = m_pend & ~m_mask;
    acc   = (m_mode == 1) && int_ack;
    for (int i = 0; i < N; i++) begin
      clr = (reg_we && reg_sel == 2'd2 && reg_wdata[i]) || (acc && m_id == i);
      if (!m_edge[i])                nxt[i] = s_now[i];
      else if (s_now[i] && !s_old[i]) nxt[i] = 1'b1;
      else if (clr)                  nxt[i] = 1'b0;
      else                           nxt[i] = m_pend[i];
    end
    if (m_mode == 0) begin
      if (int_en && elig != 0) begin m_mode = 1; m_id = lowest(elig); end
    end else if (m_mode == 1) begin
      if (int_ack) m_mode = 2;
      else if (!int_en || !elig[m_id]) m_mode = 0;
    end else if (int_done) begin
      m_mode = 0;
    end
    m_pend = nxt;
    if (reg_we && reg_sel == 2'd0) m_mask = reg_wdata[N-1:0];
    if (reg_we && reg_sel == 2'd1) m_edge = reg_wdata[N-1:0];
    q_hist.push_front(irq);
    void'(q_hist.pop_back());
  endtask

  task automatic compare_all();
    logic [31:0]   er;
    logic [AW-1:0] ev;
    ev = vec_base + AW'(m_id * (1 << SL));
    case (reg_sel)
      2'd0:    er = 32'(m_mask);
      2'd1:    er = 32'(m_edge);
      2'd2:    er = 32'(m_pend);
      default: er = {m_mode == 2, m_mode == 1, 22'b0, 8'(m_id)};
    endcase
    chk("int_req", 32'(int_req), 32'(m_mode == 1));
    chk("in_service", 32'(in_service), 32'(m_mode == 2));
    chk("int_id", 32'(int_id), 32'(m_id));
    chk("int_vector", 32'(int_vector), 32'(ev));
    chk("reg_rdata", reg_rdata, er);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    reg_we = 1'b1; reg_sel = sel; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    reg_sel = sel;
    #1;
    chk(tag, reg_rdata, exp);
  endtask

  initial begin
    logic [31:0] rst_exp [4];
    reset_ = 1'b0; irq = '0; int_en = 1'b0; reg_we = 1'b0; reg_sel = '0; reg_wdata = '0;
    int_ack = 1'b0; int_done = 1'b0;
    vec_base = AW'($urandom);
    model_reset();
    #12 reset_ = 1'b1;
    @(posedge clk); #1;

    // Reset values
    rst_exp = '{32'hFF, 32'h0, 32'h0, 32'h0};
    for (int s = 0; s < 4; s++) rd_chk("reset_reg", 2'(s), rst_exp[s]);
    chk("reset_req", 32'(int_req), 32'h0);

    // Level channel 0: request exactly four edges after the pin rises
    int_en = 1'b1;
    wr(2'd0, 32'hFE);
    irq = 8'h01;
    for (int k = 0; k < 3; k++) begin tick(); chk("lat_early", 32'(int_req), 32'h0); end
    tick();
    chk("lat_req", 32'(int_req), 32'h1);
    chk("lat_id", 32'(int_id), 32'h0);
    chk("lat_vec", 32'(int_vector), 32'(vec_base));
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("lat_svc", 32'(in_service), 32'h1);
    irq = '0;
    wr(2'd0, 32'hFF);
    int_done = 1'b1; tick(); int_done = 1'b0;
    chk("lat_done_svc", 32'(in_service), 32'h0);
    tick();
    chk("lat_idle_req", 32'(int_req), 32'h0);

    // Priority between simultaneous edge pulses on channels 5 and 2
    wr(2'd0, 32'h00);
    wr(2'd1, 32'hFF);
    irq = 8'h24; tick(); irq = '0;
    repeat (3) tick();
    chk("prio_req", 32'(int_req), 32'h1);
    chk("prio_id", 32'(int_id), 32'h2);
    chk("prio_vec", 32'(int_vector), 32'(vec_base + AW'(8)));
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_done = 1'b1; tick(); int_done = 1'b0;
    tick();
    chk("prio_id2", 32'(int_id), 32'h5);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    rd_chk("prio_pend", 2'd2, 32'h0);
    int_done = 1'b1; tick(); int_done = 1'b0;

    // Withdraw: level channel 3 drops before ack, then a mask write during REQ
    wr(2'd1, 32'hF7);
    irq = 8'h08;
    repeat (4) tick();
    chk("wd_req", 32'(int_req), 32'h1);
    chk("wd_id", 32'(int_id), 32'h3);
    irq = '0;
    repeat (4) tick();
    chk("wd_drop", 32'(int_req), 32'h0);
    irq = 8'h08;
    repeat (4) tick();
    chk("wd_req2", 32'(int_req), 32'h1);
    wr(2'd0, 32'h08);
    tick();
    chk("wd_mask", 32'(int_req), 32'h0);
    irq = '0;
    wr(2'd0, 32'hFF);
    repeat (3) tick();

    // W1C write lands on the same edge as a new edge on channel 1: the set wins
    irq = 8'h02;
    repeat (2) tick();
    wr(2'd2, 32'h02);
    rd_chk("w1c_race", 2'd2, 32'h02);

    // Reset while in service
    wr(2'd0, 32'hFD);
    tick();
    chk("rst_req", 32'(int_id), 32'h1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("rst_svc_before", 32'(in_service), 32'h1);
    #2 reset_ = 1'b0;
    #1;
    chk("rst_svc", 32'(in_service), 32'h0);
    chk("rst_req_drop", 32'(int_req), 32'h0);
    #1 reset_ = 1'b1;
    model_reset();
    int_done = 1'b1; tick(); int_done = 1'b0;
    chk("stale_done", 32'(in_service), 32'h0);
    rd_chk("post_rst_mask", 2'd0, 32'hFF);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) irq[$urandom_range(0, N - 1)] ^= 1'b1;
      int_en   = ($urandom_range(0, 15) != 0);
      reg_we   = ($urandom_range(0, 5) == 0);
      reg_sel  = 2'($urandom);
      reg_wdata = $urandom;
      if (reg_we && reg_sel == 2'd0 && $urandom_range(0, 1) == 1) reg_wdata[7:0] = 8'h00;
      int_ack  = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      int_done = (m_mode == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) vec_base = AW'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
